// File: rtl/icache_controller.sv
// Direct-mapped instruction cache controller.
// Zero-stall hits; misses fetch a 128-bit block from instruction memory
// through a READ/BUSYWAIT handshake, then refill the indexed line.
module icache_controller #(
    parameter int NUM_LINES = 8,
    parameter int ADDR_BITS = 10
) (
    input  logic                 CLK,
    input  logic                 RESET,
    input  logic                 READ,
    input  logic [31:0]          PC,
    output logic [31:0]          INSTRUCTION,
    output logic                 BUSYWAIT,
    output logic                 MEM_READ,
    output logic [ADDR_BITS-5:0] MEM_ADDRESS,
    input  logic [127:0]         MEM_READINST,
    input  logic                 MEM_BUSYWAIT
);
    localparam int IDX_W = $clog2(NUM_LINES);
    localparam int TAG_W = ADDR_BITS - 4 - IDX_W;

    typedef enum logic [1:0] {S_IDLE, S_MEM_READ, S_UPDATE} state_t;

    state_t                 state_q, state_d;
    logic [NUM_LINES-1:0]   valid_q, valid_d;
    logic [IDX_W-1:0]       idx_q, idx_d;
    logic [TAG_W-1:0]       tag_q, tag_d;
    logic                   first_q, first_d;
    logic                   fill_en;
    logic [127:0]           fill_q;

    logic [TAG_W-1:0]       tag_mem  [NUM_LINES];
    logic [127:0]           data_mem [NUM_LINES];

    logic [1:0]             offset;
    logic [IDX_W-1:0]       index;
    logic [TAG_W-1:0]       tag;
    logic                   hit;
    logic                   unused_pc_bits;

    assign offset = PC[3:2];
    assign index  = PC[3+IDX_W:4];
    assign tag    = PC[ADDR_BITS-1:4+IDX_W];
    assign hit    = READ & valid_q[index] & (tag_mem[index] == tag);

    // Byte-offset and out-of-range PC bits are deliberately ignored.
    assign unused_pc_bits = ^{PC[31:ADDR_BITS], PC[1:0]};

    // Memory is addressed from the latched miss, so a wandering PC cannot
    // redirect an in-flight fill.
    assign MEM_ADDRESS = {tag_q, idx_q};

    // Next-state, handshake outputs and hit data path.
    always_comb begin
        state_d     = state_q;
        valid_d     = valid_q;
        idx_d       = idx_q;
        tag_d       = tag_q;
        first_d     = 1'b0;
        fill_en     = 1'b0;
        BUSYWAIT    = 1'b0;
        MEM_READ    = 1'b0;
        INSTRUCTION = 32'h0;
        case (state_q)
            S_IDLE: begin
                if (READ) begin
                    if (hit) begin
                        INSTRUCTION = data_mem[index][offset*32 +: 32];
                    end else begin
                        BUSYWAIT = 1'b1;
                        idx_d    = index;
                        tag_d    = tag;
                        first_d  = 1'b1;
                        state_d  = S_MEM_READ;
                    end
                end
            end
            S_MEM_READ: begin
                MEM_READ = 1'b1;
                BUSYWAIT = 1'b1;
                // Memory busy rises combinationally with the request, so the
                // first cycle's busy level is not trusted.
                if (!first_q && !MEM_BUSYWAIT) begin
                    fill_en = 1'b1;
                    state_d = S_UPDATE;
                end
            end
            S_UPDATE: begin
                BUSYWAIT        = 1'b1;
                valid_d[idx_q]  = 1'b1;
                state_d         = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    // Control state; reset invalidates every line and aborts any miss.
    always_ff @(posedge CLK or negedge RESET) begin
        if (!RESET) begin
            state_q <= S_IDLE;
            valid_q <= '0;
            idx_q   <= '0;
            tag_q   <= '0;
            first_q <= 1'b0;
        end else begin
            state_q <= state_d;
            valid_q <= valid_d;
            idx_q   <= idx_d;
            tag_q   <= tag_d;
            first_q <= first_d;
        end
    end

    // Fill register and line storage; contents are qualified by valid_q.
    always_ff @(posedge CLK) begin
        if (fill_en) begin
            fill_q <= MEM_READINST;
        end
        if (state_q == S_UPDATE) begin
            data_mem[idx_q] <= fill_q;
            tag_mem[idx_q]  <= tag_q;
        end
    end

endmodule

// File: tb/tb_icache_controller.sv
// Directed bench for icache_controller with a fixed-latency block memory model.
module tb_icache_controller;
    logic         CLK = 1'b0;
    logic         RESET;
    logic         READ;
    logic [31:0]  PC;
    logic [31:0]  INSTRUCTION;
    logic         BUSYWAIT;
    logic         MEM_READ;
    logic [5:0]   MEM_ADDRESS;
    logic [127:0] MEM_READINST;
    logic         MEM_BUSYWAIT;

    int nchk = 0;
    int nerr = 0;
    int mcnt = 0;

    localparam logic [127:0] BLK0 = {32'h00736393, 32'h0062F3B3, 32'h00300313, 32'h00100293};

    icache_controller #(.NUM_LINES(8), .ADDR_BITS(10)) dut (
        .CLK(CLK), .RESET(RESET), .READ(READ), .PC(PC),
        .INSTRUCTION(INSTRUCTION), .BUSYWAIT(BUSYWAIT),
        .MEM_READ(MEM_READ), .MEM_ADDRESS(MEM_ADDRESS),
        .MEM_READINST(MEM_READINST), .MEM_BUSYWAIT(MEM_BUSYWAIT)
    );

    always #5 CLK = ~CLK;

    // Block contents: address 0 is the program block, others are patterned.
    function automatic logic [127:0] blk(input logic [5:0] a);
        logic [31:0] base;
        if (a == 6'd0) return BLK0;
        base = 32'hA000_0000 + ({26'd0, a} << 8);
        return {base + 32'd3, base + 32'd2, base + 32'd1, base};
    endfunction

    // Memory: busy for 5 request cycles, data valid on the 6th.
    always @(posedge CLK) begin
        if (!MEM_READ) mcnt <= 0;
        else           mcnt <= mcnt + 1;
    end
    assign MEM_BUSYWAIT = MEM_READ && (mcnt < 5);
    assign MEM_READINST = (MEM_READ && mcnt >= 5) ? blk(MEM_ADDRESS) : 128'h0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        nchk++;
        if (got !== exp) begin
            nerr++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    // Run a full miss from IDLE; counts stall and request cycles, checks first hit.
    task automatic run_miss(input string tag, input logic [31:0] pc, input logic [5:0] exp_addr,
                            input logic [31:0] exp_instr);
        int bw = 0;
        int mr = 0;
        logic [5:0] addr = '1;
        PC = pc;
        READ = 1'b1;
        for (int c = 0; c < 40; c++) begin
            @(negedge CLK);
            if (!BUSYWAIT) break;
            bw++;
            if (MEM_READ) begin
                mr++;
                addr = MEM_ADDRESS;
            end
            @(posedge CLK);
            #1;
        end
        chk({tag, "_busy_cycles"}, bw, 8);
        chk({tag, "_memrd_cycles"}, mr, 6);
        chk({tag, "_mem_addr"}, {26'd0, addr}, {26'd0, exp_addr});
        chk({tag, "_hit_instr"}, INSTRUCTION, exp_instr);
        @(posedge CLK);
        #1;
    endtask

    task automatic hit(input string tag, input logic [31:0] pc, input logic [31:0] exp);
        PC = pc;
        READ = 1'b1;
        @(negedge CLK);
        chk({tag, "_busy"}, {31'd0, BUSYWAIT}, 32'd0);
        chk({tag, "_memrd"}, {31'd0, MEM_READ}, 32'd0);
        chk({tag, "_instr"}, INSTRUCTION, exp);
        @(posedge CLK);
        #1;
    endtask

    task automatic idle_checks(input string tag);
        chk({tag, "_busy"}, {31'd0, BUSYWAIT}, 32'd0);
        chk({tag, "_memrd"}, {31'd0, MEM_READ}, 32'd0);
        chk({tag, "_instr"}, INSTRUCTION, 32'd0);
    endtask

    initial begin
        int bw;
        int mr;
        RESET = 1'b0;
        READ  = 1'b0;
        PC    = 32'h0;
        repeat (2) @(posedge CLK);
        #1 RESET = 1'b1;
        @(negedge CLK);
        idle_checks("reset0");
        @(posedge CLK);
        #1;

        // Cold miss and spatial hits.
        run_miss("cold", 32'h000, 6'h00, 32'h00100293);
        hit("hit4", 32'h004, 32'h00300313);
        hit("hit8", 32'h008, 32'h0062F3B3);
        hit("hitC", 32'h00C, 32'h00736393);
        hit("hit7", 32'h007, 32'h00300313);
        hit("hi_bits", 32'hFFFF_FC08, 32'h0062F3B3);

        // Conflict: tag 1 evicts tag 0 from line 0, then tag 0 misses again.
        run_miss("confl", 32'h080, 6'h08, 32'hA000_0800);
        hit("confl_hit", 32'h088, 32'hA000_0802);
        run_miss("remiss", 32'h000, 6'h00, 32'h00100293);

        // Mid-simulation reset invalidates the cache.
        READ = 1'b0;
        RESET = 1'b0;
        @(negedge CLK);
        @(posedge CLK);
        #1 RESET = 1'b1;
        @(negedge CLK);
        idle_checks("reset1");
        @(posedge CLK);
        #1;
        run_miss("post_rst", 32'h000, 6'h00, 32'h00100293);

        // Reset on the third MEM_READ cycle aborts the fill.
        PC = 32'h080;
        READ = 1'b1;
        mr = 0;
        for (int c = 0; c < 40 && mr < 3; c++) begin
            @(negedge CLK);
            if (MEM_READ) mr++;
        end
        chk("abort_reached", mr, 3);
        RESET = 1'b0;
        READ = 1'b0;
        #1;
        idle_checks("abort");
        repeat (8) @(posedge CLK);
        #1 RESET = 1'b1;
        @(posedge CLK);
        #1;
        run_miss("abort_remiss", 32'h000, 6'h00, 32'h00100293);

        // READ dropped after the miss cycle: the fill still completes.
        PC = 32'h010;
        READ = 1'b1;
        bw = 0;
        for (int c = 0; c < 40; c++) begin
            @(negedge CLK);
            if (!BUSYWAIT) break;
            bw++;
            @(posedge CLK);
            #1 READ = 1'b0;
        end
        chk("drop_busy_cycles", bw, 8);
        @(posedge CLK);
        #1;
        hit("drop_hit", 32'h014, 32'hA000_0101);

        // Idle with an uncached PC: no request, no stall, zero output.
        PC = 32'h3F0;
        READ = 1'b0;
        for (int c = 0; c < 10; c++) begin
            @(negedge CLK);
            idle_checks("noread");
        end

        $display("Result: errors=%0d of %0d checks", nerr, nchk);
        $finish;
    end
endmodule
